// File: rtl/if_fetch_buf.sv
// if_fetch_buf: instruction fetch sequencer with a small {pc, inst} buffer
// feeding the IF_ID stage. Issues reads only while buffer space is assured
// (credit = count + inflight), so a returning response always has a slot.
// Optional macro FETCH_BYPASS_EN: a response that arrives while the buffer
// is empty is presented directly on the outputs in its arrival cycle.
module if_fetch_buf #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_re,
    output logic [PC_WIDTH-1:0] imem_raddr,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [PC_WIDTH-1:0] out_pc_o,
    output logic [31:0]         out_inst_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                inflight_q, inflight_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic [PC_WIDTH-1:0] fifo_pc_q   [DEPTH];
    logic [31:0]         fifo_inst_q [DEPTH];

    logic [CNT_W:0]      used_w;
    logic                credit_ok_w;
    logic                resp_w;
    logic                fifo_nonempty_w;
    logic                push_w;
    logic                pop_w;
`ifdef FETCH_BYPASS_EN
    logic                byp_w;
`endif

    // Slots already committed: buffered entries plus the read still in flight.
    assign used_w          = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok_w     = (used_w < (CNT_W + 1)'(DEPTH));
    assign resp_w          = inflight_q && !redirect_i;
    assign fifo_nonempty_w = (count_q != '0);
    assign pop_w           = fifo_nonempty_w && out_ready_i;
    assign imem_raddr      = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
    // A response into an empty buffer goes straight out; it is only stored
    // if IF_ID cannot take it this cycle.
    assign byp_w  = resp_w && !fifo_nonempty_w;
    assign push_w = resp_w && !(byp_w && out_ready_i);
`else
    assign push_w = resp_w;
`endif

    // State register: BOOT holds for one cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: BOOT always moves to RUN; RUN is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // FSM output: issue a read in RUN when no redirect and a slot is free.
    always_comb begin
        imem_re = 1'b0;
        if (state_q == ST_RUN) begin
            imem_re = !redirect_i && credit_ok_w;
        end
    end

    // Next-state for fetch address, buffer pointers/count and in-flight tracking.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        inflight_d    = imem_re;
        inflight_pc_d = inflight_pc_q;
        if (redirect_i) begin
            // Flush everything, including the response arriving now.
            fetch_pc_d = redirect_pc_i;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (imem_re) begin
                fetch_pc_d    = fetch_pc_q + PC_WIDTH'(4);
                inflight_pc_d = fetch_pc_q;
            end
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers, cleared asynchronously so outputs drop at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    // Data storage: contents are qualified by count/inflight, so no reset.
    always_ff @(posedge clk) begin
        inflight_pc_q <= inflight_pc_d;
        if (push_w) begin
            fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
            fifo_inst_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // Offer the buffer head (or the bypassed response); zero when idle.
    always_comb begin
        out_valid_o = fifo_nonempty_w;
        out_pc_o    = '0;
        out_inst_o  = '0;
        if (fifo_nonempty_w) begin
            out_pc_o   = fifo_pc_q[rd_ptr_q];
            out_inst_o = fifo_inst_q[rd_ptr_q];
        end
`ifdef FETCH_BYPASS_EN
        else if (byp_w) begin
            out_valid_o = 1'b1;
            out_pc_o    = inflight_pc_q;
            out_inst_o  = imem_rdata;
        end
`endif
    end

endmodule

// File: tb/tb_if_fetch_buf.sv
module tb_if_fetch_buf;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_BYPASS_EN
  localparam int          BYP    = 1;
`else
  localparam int          BYP    = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_re;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_deliv  = 0;
  int          lat;
  int          base;
  logic [31:0] e;
  logic [31:0] exp_q[$];

  if_fetch_buf #(
    .PC_WIDTH (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_re       (imem_re),
    .imem_raddr    (imem_raddr),
    .imem_rdata    (imem_rdata),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_pc_o      (out_pc_o),
    .out_inst_o    (out_inst_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_1234;
  endfunction

  always @(posedge clk) begin
    if (imem_re) imem_rdata <= inst_of(imem_raddr);
  end

  always @(negedge clk) begin
    if (out_valid_o && out_ready_i && !redirect_i) begin
      n_deliv++;
      chk("sb_unexpected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc_o, e);
        chk("sb_inst", out_inst_o, inst_of(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic load_exp(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 48; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!out_valid_o && l < 12) begin
      cyc();
      smp();
      l++;
    end
    chk("valid_timeout", 32'(out_valid_o), 32'd1);
  endtask

  initial begin
    rst           = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    out_ready_i   = 1'b1;
    load_exp(RST_PC);

    smp();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_pc", out_pc_o, 32'h0);
    chk("rst_inst", out_inst_o, 32'h0);
    chk("rst_re", 32'(imem_re), 32'd0);
    chk("rst_raddr", imem_raddr, RST_PC);

    cyc(); rst = 1'b1;
    smp();
    chk("boot_re", 32'(imem_re), 32'd0);
    cyc(); smp();
    chk("run_re", 32'(imem_re), 32'd1);
    chk("run_raddr", imem_raddr, RST_PC);
    wait_valid(lat);
    chk("latency", 32'(lat), 32'(2 - BYP));
    chk("b2b_pc0", out_pc_o, RST_PC);
    cyc(); smp();
    chk("b2b_pc1", out_pc_o, RST_PC + 32'd4);
    cyc(); smp();
    chk("b2b_pc2", out_pc_o, RST_PC + 32'd8);

    cyc(); out_ready_i = 1'b0;
    smp();
    chk("stall_head", out_pc_o, RST_PC + 32'd12);
    repeat (9) begin
      cyc(); smp();
      chk("stall_valid", 32'(out_valid_o), 32'd1);
      chk("stall_stable", out_pc_o, RST_PC + 32'd12);
    end
    chk("stall_full_re", 32'(imem_re), 32'd0);
    cyc(); out_ready_i = 1'b1;
    base = n_deliv;
    repeat (8) begin
      smp(); cyc();
    end
    chk("release_count", 32'(n_deliv - base), 32'd8);

    out_ready_i = 1'b0;
    repeat (8) begin
      smp(); cyc();
    end
    smp();
    chk("s3_full_re", 32'(imem_re), 32'd0);
    cyc(); out_ready_i = 1'b1;
    smp();
    cyc(); out_ready_i = 1'b0;
    smp();
    chk("s3_refill_re", 32'(imem_re), 32'd1);
    cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_2000;
    load_exp(32'h0000_2000);
    smp();
    chk("redir_re", 32'(imem_re), 32'd0);
    chk("redir_buffered", 32'(out_valid_o), 32'd1);
    cyc(); redirect_i = 1'b0; out_ready_i = 1'b1;
    smp();
    chk("redir_valid_next", 32'(out_valid_o), 32'd0);
    chk("redir_re_next", 32'(imem_re), 32'd1);
    chk("redir_raddr", imem_raddr, 32'h0000_2000);
    wait_valid(lat);
    chk("redir_latency", 32'(lat), 32'(2 - BYP));
    chk("redir_first_pc", out_pc_o, 32'h0000_2000);

    repeat (3) begin
      cyc(); smp();
    end
    cyc(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    load_exp(32'hFFFF_FFF8);
    smp();
    cyc(); redirect_i = 1'b0;
    smp();
    wait_valid(lat);
    chk("wrap_pc0", out_pc_o, 32'hFFFF_FFF8);
    cyc(); smp();
    chk("wrap_pc1", out_pc_o, 32'hFFFF_FFFC);
    cyc(); smp();
    chk("wrap_pc2", out_pc_o, 32'h0000_0000);

    repeat (3) begin
      cyc(); smp();
    end
    cyc(); out_ready_i = 1'b0;
    smp();
    repeat (BYP) begin
      cyc(); smp();
    end
    chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
    cyc(); rst = 1'b0;
    #1;
    chk("rst2_valid", 32'(out_valid_o), 32'd0);
    chk("rst2_pc", out_pc_o, 32'h0);
    chk("rst2_inst", out_inst_o, 32'h0);
    chk("rst2_re", 32'(imem_re), 32'd0);
    chk("rst2_raddr", imem_raddr, RST_PC);
    load_exp(RST_PC);
    out_ready_i = 1'b1;
    cyc(); rst = 1'b1;
    smp();
    chk("boot2_re", 32'(imem_re), 32'd0);
    wait_valid(lat);
    chk("rst2_latency", 32'(lat), 32'(3 - BYP));
    chk("rst2_first_pc", out_pc_o, RST_PC);

    repeat (2) begin
      cyc(); smp();
    end
    cyc(); rst = 1'b0;
    cyc(); rst = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_3000;
    load_exp(32'h0000_3000);
    smp();
    chk("bootredir_re", 32'(imem_re), 32'd0);
    cyc(); redirect_i = 1'b0;
    smp();
    chk("bootredir_re1", 32'(imem_re), 32'd1);
    chk("bootredir_raddr", imem_raddr, 32'h0000_3000);
    wait_valid(lat);
    chk("bootredir_pc", out_pc_o, 32'h0000_3000);
    repeat (4) begin
      cyc(); smp();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_buf.md
IF_FETCH_BUF -- requirements
Module: if_fetch_buf

Interface
REQ-001 The block SHALL have parameters, one per line:
 - PC_WIDTH, 32, width of the fetch address.
 - DEPTH, 4, instruction buffer entries (power of two, 2..16).
 - RESET_PC, 0, first fetch address after reset.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports, one per line:
 - clk  in  1  clock; all state changes on its rising edge.
 - rst  in  1  asynchronous active-low reset.
 - imem_re  out  1  instruction memory read strobe.
 - imem_raddr  out  PC_WIDTH  instruction memory read address.
 - imem_rdata  in  32  read data, valid the cycle after imem_re=1.
 - redirect_i  in  1  pipeline redirect (branch/jump) request.
 - redirect_pc_i  in  PC_WIDTH  target address for the redirect.
 - out_valid_o  out  1  instruction available toward IF_ID.
 - out_ready_i  in  1  IF_ID accepts; deasserted on stall.
 - out_pc_o  out  PC_WIDTH  PC of the offered instruction.
 - out_inst_o  out  32  offered instruction.

Function
REQ-004 The block SHALL hold fetch_pc, a FIFO of DEPTH {pc, inst} entries, count (0..DEPTH), an inflight flag with its inflight_pc, and state in {BOOT, RUN}.
REQ-005 imem_raddr SHALL equal fetch_pc at all times.
REQ-006 BOOT SHALL last exactly one cycle after reset release with imem_re=0, then go to RUN; RUN SHALL be left only by reset.
REQ-007 In RUN, imem_re SHALL be 1 iff redirect_i=0 and count+inflight < DEPTH.
REQ-008 On issue, the block SHALL set inflight=1, set inflight_pc=fetch_pc and advance fetch_pc by 4 modulo 2^PC_WIDTH (0xFFFFFFFC wraps to 0x00000000).
REQ-009 When inflight=1 and no redirect occurs, the block SHALL write {inflight_pc, imem_rdata} into the FIFO in that cycle.
REQ-010 out_valid_o SHALL be (count != 0); out_pc_o/out_inst_o SHALL show the FIFO head and SHALL be 0 when out_valid_o=0.
REQ-011 The FIFO SHALL pop when out_valid_o=1 and out_ready_i=1; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-012 Offered outputs SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-013 The credit rule SHALL guarantee that a push never hits a full FIFO; count SHALL never exceed DEPTH.
REQ-014 redirect_i=1 SHALL clear the FIFO (count=0), drop the arriving in-flight response, clear inflight, load fetch_pc with redirect_pc_i and suppress imem_re in that cycle.
REQ-015 Fetching at the new target SHALL begin the cycle after the redirect; out_valid_o SHALL be 0 the cycle after the redirect, even if out_ready_i was 1.
REQ-016 redirect_i during BOOT SHALL load fetch_pc, and BOOT SHALL still complete.
REQ-017 Latency, issue to out_valid_o, SHALL be 2 cycles with an empty FIFO.

Reset
REQ-018 rst=0 SHALL immediately force: state=BOOT, fetch_pc=RESET_PC, count=0, inflight=0, imem_re=0, out_valid_o=0, out_pc_o=0, out_inst_o=0.
REQ-019 Reset asserted mid-fetch SHALL discard all buffered and in-flight instructions; no pre-reset instruction SHALL appear after release.

Configuration
REQ-020 Macro FETCH_BYPASS_EN SHALL select the bypass path.
 - Defined: when count=0 and a response arrives without redirect, the block SHALL present it directly on the outputs in the arrival cycle (latency 1).
 - With the bypass, if out_ready_i=1 the response SHALL NOT be written to the FIFO.
 - Not defined: latency SHALL be exactly as REQ-017; no bypass logic.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
 - Reset release, RESET_PC=0x100, out_ready_i=1 -> imem_re rises after one BOOT cycle; outputs pc 0x100, 0x104, 0x108 back-to-back, one per cycle.
 - out_ready_i=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered, imem_re=0 afterwards; on release 4 in-order pops, no loss or duplicate.
 - Redirect to 0x2000 while 3 entries buffered and one in flight -> out_valid_o=0 next cycle; next delivered pc=0x2000; no stale pc delivered.
 - fetch_pc=0xFFFFFFF8, ready=1 -> pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 delivered.
 - rst pulsed low mid-stream with 2 buffered -> outputs 0 immediately; first pc after release=RESET_PC.
 - With and without FETCH_BYPASS_EN, empty FIFO, ready=1 -> issue-to-valid measured as 1 and 2 cycles respectively.
